// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared widths and helpers for the instruction fetch block.
//   WORD_W   : width of one instruction
//   ADDR_W   : width of an instruction-memory word address
//   bundle_w : width of the bundle returned for a given number of cores
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  function automatic int bundle_w(input int cores);
    return WORD_W * cores;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the instruction-memory read port, the halt/redirect controls and
//   the decode-side valid/ready handshake of the fetch unit.
//   master : the fetch unit (drives imem_address and the out_* bundle)
//   slave  : the environment (memory, control and decode)
//   Signals:
//     imem_address   fetch -> mem     word address, sampled on every edge
//     imem_data      mem   -> fetch   registered read data, one cycle later
//     halt           ctrl  -> fetch   stop issuing new fetches
//     redirect_valid ctrl  -> fetch   discard fetched work, restart at redirect_pc
//     redirect_pc    ctrl  -> fetch   redirect target word address
//     out_valid      fetch -> decode  out_bundle/out_pc hold a fetched bundle
//     out_ready      decode-> fetch   bundle accepted when out_valid & out_ready
//     out_bundle     fetch -> decode  fetched bundle, core k in bits [32k+31:32k]
//     out_pc         fetch -> decode  word address out_bundle was read from
// -----------------------------------------------------------------------------
interface instruction_fetch_if #(
  parameter int CORES = 1
);
  import fetch_pkg::*;

  logic [ADDR_W-1:0]            imem_address;
  logic [bundle_w(CORES)-1:0]   imem_data;
  logic                         halt;
  logic                         redirect_valid;
  logic [ADDR_W-1:0]            redirect_pc;
  logic                         out_valid;
  logic                         out_ready;
  logic [bundle_w(CORES)-1:0]   out_bundle;
  logic [ADDR_W-1:0]            out_pc;

  modport master (
    output imem_address, out_valid, out_bundle, out_pc,
    input  imem_data, halt, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_address, out_valid, out_bundle, out_pc,
    output imem_data, halt, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small shifting buffer for fetched {bundle, pc} entries. Entry 0 is always
//   the head, so the head is a plain register with no read-side mux logic.
//   Ports:
//     clk, reset  clock, asynchronous active-high reset
//     flush       drop all entries (wins over a same-cycle push)
//     push        write push_data behind the current entries
//     push_data   entry to write
//     pop         remove the head (ignored when empty)
//     head_data   registered head entry
//     count       number of valid entries
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wr_idx;
  logic             pop_ok;

  assign pop_ok = pop & (count_q != '0);
  // With a simultaneous pop the entries slide down first, so the new entry
  // lands one slot lower; this keeps push+pop on a full buffer legal.
  assign wr_idx = count_q - CNT_W'(pop_ok);

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    data_d  = data_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          data_d[i] = data_q[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == wr_idx) begin
            data_d[i] = push_data;
          end
        end
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is reset as well, so the head (and therefore
      // out_bundle/out_pc) reads zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so all
      // flops see pre-edge values regardless of statement order.
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign head_data = data_q[0];
  assign count     = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Initiator side of the instruction-memory read port. Holds the PC, drives
//   one word address per cycle, captures the bundle returned one cycle later,
//   buffers it and presents it to decode over valid/ready. Supports halt and
//   branch redirect.
//   Parameters:
//     CORES      instructions per memory word (bundle is 32*CORES bits)
//     RESET_PC   first word address fetched after reset
//     FIFO_DEPTH output buffer entries, 2..8
//   Ports:
//     clk    single clock, all state on posedge
//     reset  asynchronous, active-high
//     bus    instruction_fetch_if master modport (memory, control, decode)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int          CORES      = 1,
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);
  import fetch_pkg::*;

  localparam int BUNDLE_W = bundle_w(CORES);
  localparam int ENTRY_W  = BUNDLE_W + ADDR_W;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W    = CNT_W + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic               inflight_valid_q, inflight_valid_d;

  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [OCC_W-1:0]   occupancy;
  logic               pop;
  logic               push;
  logic               issue;

  assign pop = bus.out_valid & bus.out_ready;

  // Credit check: entries that will still be held after this edge, counting
  // the read already in flight. A new read is only issued when its data is
  // guaranteed a slot when it returns.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_valid_q) - OCC_W'(pop);
  assign issue     = ~bus.halt & ~bus.redirect_valid
                   & (occupancy < OCC_W'(FIFO_DEPTH));

  // Returning data is captured only when its read was issued; a redirect
  // flushes the buffer and drops the read that is arriving this cycle.
  assign push = inflight_valid_q;

  always_comb begin
    pc_d             = pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = 1'b0;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end else if (issue) begin
      inflight_valid_d = 1'b1;
      inflight_pc_d    = pc_q;
      pc_d             = pc_q + 1'b1;  // wraps FFFF_FFFF -> 0
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data ({bus.imem_data, inflight_pc_q}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // The memory samples the address every edge; there is no read enable.
  assign bus.imem_address = pc_q;
  assign bus.out_valid    = (fifo_count != '0);
  assign bus.out_pc       = fifo_head[ADDR_W-1:0];
  assign bus.out_bundle   = fifo_head[ENTRY_W-1:ADDR_W];

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. dut0: CORES=1, RESET_PC=8, depth 2,
//   memory word = address. dut4: CORES=4, RESET_PC=0, depth 4, memory word =
//   {a+3000_0000, a+2000_0000, a+1000_0000, a}. Inputs change and outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic reset0;
  logic reset4;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_if #(.CORES(1)) bus0 ();
  instruction_fetch_if #(.CORES(4)) bus4 ();

  instruction_fetch #(
    .CORES(1), .RESET_PC(32'd8), .FIFO_DEPTH(2)
  ) dut0 (
    .clk   (clk),
    .reset (reset0),
    .bus   (bus0.master)
  );

  instruction_fetch #(
    .CORES(4), .RESET_PC(32'd0), .FIFO_DEPTH(4)
  ) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4.master)
  );

  // Registered instruction memories.
  always @(posedge clk) bus0.imem_data <= bus0.imem_address;
  always @(posedge clk)
    bus4.imem_data <= {bus4.imem_address + 32'h3000_0000,
                       bus4.imem_address + 32'h2000_0000,
                       bus4.imem_address + 32'h1000_0000,
                       bus4.imem_address};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset0 = 1'b1;
    bus0.out_ready = 1'b1;
    cyc(); cyc();
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", bus0.out_valid);
    end
    checks++;
    if ({bus0.out_pc, bus0.out_bundle} !== 64'd0) begin
      errors++; $display("FAIL reset_head: got pc=%h bundle=%h want 0/0", bus0.out_pc, bus0.out_bundle);
    end
    checks++;
    if (bus0.imem_address !== 32'd8) begin
      errors++; $display("FAIL reset_addr: got %h want 8", bus0.imem_address);
    end
    reset0 = 1'b0;
    cyc();
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_cycle2: got valid=%b want 0", bus0.out_valid);
    end
    cyc();
    checks++;
    if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'd8}) begin
      errors++; $display("FAIL latency_cycle3: got valid=%b pc=%h want 1/8", bus0.out_valid, bus0.out_pc);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      exp = 32'd8 + 32'(i);
      checks++;
      if ({bus0.out_valid, bus0.out_pc, bus0.out_bundle} !== {1'b1, exp, exp}) begin
        errors++; $display("FAIL stream[%0d]: got valid=%b pc=%h bundle=%h want pc=bundle=%h",
                           i, bus0.out_valid, bus0.out_pc, bus0.out_bundle, exp);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    reset0 = 1'b1;
    bus0.out_ready = 1'b0;
    cyc();
    reset0 = 1'b0;
    cyc(); cyc();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus0.out_valid, bus0.out_pc, bus0.imem_address} !== {1'b1, 32'd8, 32'd10}) begin
        errors++; $display("FAIL stall[%0d]: got valid=%b pc=%h addr=%h want 1/8/a",
                           k, bus0.out_valid, bus0.out_pc, bus0.imem_address);
      end
      cyc();
    end
    bus0.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'd8 + 32'(j)}) begin
        errors++; $display("FAIL release[%0d]: got valid=%b pc=%h want pc=%h",
                           j, bus0.out_valid, bus0.out_pc, 32'd8 + 32'(j));
      end
      cyc();
    end
  endtask

  task automatic test_redirect();
    // Fill the buffer (head 12, then 13 behind it), then redirect with a pop.
    bus0.out_ready = 1'b0;
    cyc();
    checks++;
    if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'd12}) begin
      errors++; $display("FAIL redir_pre: got valid=%b pc=%h want 1/c", bus0.out_valid, bus0.out_pc);
    end
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'h40;
    bus0.out_ready      = 1'b1;
    cyc();
    bus0.redirect_valid = 1'b0;
    checks++;
    if ({bus0.out_valid, bus0.imem_address} !== {1'b0, 32'h40}) begin
      errors++; $display("FAIL redir_r1: got valid=%b addr=%h want 0/40", bus0.out_valid, bus0.imem_address);
    end
    cyc();
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL redir_r2: got valid=%b want 0", bus0.out_valid);
    end
    cyc();
    checks++;
    if ({bus0.out_valid, bus0.out_pc, bus0.out_bundle} !== {1'b1, 32'h40, 32'h40}) begin
      errors++; $display("FAIL redir_r3: got valid=%b pc=%h bundle=%h want 1/40/40",
                         bus0.out_valid, bus0.out_pc, bus0.out_bundle);
    end
    cyc();
    checks++;
    if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'h41}) begin
      errors++; $display("FAIL redir_r4: got valid=%b pc=%h want 1/41", bus0.out_valid, bus0.out_pc);
    end
    cyc();
    // Back-to-back redirects while streaming: the second one wins.
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'h100;
    cyc();
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got valid=%b want 0", bus0.out_valid);
    end
    bus0.redirect_pc = 32'h80;
    cyc();
    bus0.redirect_valid = 1'b0;
    checks++;
    if ({bus0.out_valid, bus0.imem_address} !== {1'b0, 32'h80}) begin
      errors++; $display("FAIL b2b_addr: got valid=%b addr=%h want 0/80", bus0.out_valid, bus0.imem_address);
    end
    cyc();
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: got valid=%b want 0", bus0.out_valid);
    end
    cyc();
    checks++;
    if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'h80}) begin
      errors++; $display("FAIL b2b_first_out: got valid=%b pc=%h want 1/80", bus0.out_valid, bus0.out_pc);
    end
    cyc();
    checks++;
    if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'h81}) begin
      errors++; $display("FAIL b2b_second_out: got valid=%b pc=%h want 1/81", bus0.out_valid, bus0.out_pc);
    end
    cyc();
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'hFFFF_FFFE;
    cyc();
    bus0.redirect_valid = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      exp = 32'hFFFF_FFFE + 32'(i);
      checks++;
      if ({bus0.out_valid, bus0.out_pc, bus0.out_bundle} !== {1'b1, exp, exp}) begin
        errors++; $display("FAIL wrap[%0d]: got valid=%b pc=%h bundle=%h want %h",
                           i, bus0.out_valid, bus0.out_pc, bus0.out_bundle, exp);
      end
      cyc();
    end
  endtask

  task automatic test_halt();
    logic [31:0] p;
    p = 32'd2;  // head after the wrap sequence
    bus0.halt = 1'b1;
    checks++;
    if ({bus0.out_valid, bus0.out_pc} !== {1'b1, p}) begin
      errors++; $display("FAIL halt_h0: got valid=%b pc=%h want 1/%h", bus0.out_valid, bus0.out_pc, p);
    end
    cyc();
    checks++;
    if ({bus0.out_valid, bus0.out_pc, bus0.imem_address} !== {1'b1, p + 32'd1, p + 32'd2}) begin
      errors++; $display("FAIL halt_h1: got valid=%b pc=%h addr=%h want 1/%h/%h",
                         bus0.out_valid, bus0.out_pc, bus0.imem_address, p + 32'd1, p + 32'd2);
    end
    cyc();
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL halt_h2: got valid=%b want 0", bus0.out_valid);
    end
    cyc();
    checks++;
    if ({bus0.out_valid, bus0.imem_address} !== {1'b0, p + 32'd2}) begin
      errors++; $display("FAIL halt_h3: got valid=%b addr=%h want 0/%h", bus0.out_valid, bus0.imem_address, p + 32'd2);
    end
    cyc();
    bus0.halt = 1'b0;
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL halt_h4: got valid=%b want 0", bus0.out_valid);
    end
    cyc();
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL halt_h5: got valid=%b want 0", bus0.out_valid);
    end
    cyc();
    checks++;
    if ({bus0.out_valid, bus0.out_pc} !== {1'b1, p + 32'd2}) begin
      errors++; $display("FAIL halt_resume0: got valid=%b pc=%h want 1/%h", bus0.out_valid, bus0.out_pc, p + 32'd2);
    end
    cyc();
    checks++;
    if ({bus0.out_valid, bus0.out_pc} !== {1'b1, p + 32'd3}) begin
      errors++; $display("FAIL halt_resume1: got valid=%b pc=%h want 1/%h", bus0.out_valid, bus0.out_pc, p + 32'd3);
    end
    cyc();
    // Redirect while halted: pc moves, nothing is issued until halt drops.
    bus0.halt           = 1'b1;
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'h200;
    cyc();
    bus0.redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus0.out_valid, bus0.imem_address} !== {1'b0, 32'h200}) begin
        errors++; $display("FAIL halt_redir[%0d]: got valid=%b addr=%h want 0/200",
                           k, bus0.out_valid, bus0.imem_address);
      end
      cyc();
    end
    bus0.halt = 1'b0;
    cyc(); cyc();
    checks++;
    if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL halt_redir_out: got valid=%b pc=%h want 1/200", bus0.out_valid, bus0.out_pc);
    end
  endtask

  task automatic test_cores4();
    logic [127:0] bnd;
    logic [31:0]  a;
    reset4 = 1'b0;
    cyc();
    checks++;
    if (bus4.out_valid !== 1'b0) begin
      errors++; $display("FAIL c4_cycle2: got valid=%b want 0", bus4.out_valid);
    end
    cyc();
    for (int i = 0; i < 4; i++) begin
      a   = 32'(i);
      bnd = bus4.out_bundle;
      checks++;
      if ({bus4.out_valid, bus4.out_pc, bnd[31:0], bnd[63:32], bnd[127:96]} !==
          {1'b1, a, a, a + 32'h1000_0000, a + 32'h3000_0000}) begin
        errors++; $display("FAIL c4_lanes[%0d]: got valid=%b pc=%h bundle=%h want pc=%h",
                           i, bus4.out_valid, bus4.out_pc, bnd, a);
      end
      cyc();
    end
    // Depth-4 buffer under back-pressure: pcs 4..7 held, address parked at 8.
    bus4.out_ready = 1'b0;
    repeat (5) cyc();
    checks++;
    if ({bus4.out_valid, bus4.out_pc, bus4.imem_address} !== {1'b1, 32'd4, 32'd8}) begin
      errors++; $display("FAIL c4_full: got valid=%b pc=%h addr=%h want 1/4/8",
                         bus4.out_valid, bus4.out_pc, bus4.imem_address);
    end
    bus4.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      checks++;
      if ({bus4.out_valid, bus4.out_pc} !== {1'b1, 32'd4 + 32'(j)}) begin
        errors++; $display("FAIL c4_drain[%0d]: got valid=%b pc=%h want %h",
                           j, bus4.out_valid, bus4.out_pc, 32'd4 + 32'(j));
      end
      cyc();
    end
    // Asynchronous reset pulse mid-stream, well away from any clock edge.
    #2 reset4 = 1'b1;
    #1;
    checks++;
    if ({bus4.out_valid, bus4.out_pc, bus4.imem_address} !== {1'b0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL c4_async_reset: got valid=%b pc=%h addr=%h want 0/0/0",
                         bus4.out_valid, bus4.out_pc, bus4.imem_address);
    end
    checks++;
    if (bus4.out_bundle !== 128'd0) begin
      errors++; $display("FAIL c4_async_bundle: got %h want 0", bus4.out_bundle);
    end
    cyc();
    reset4 = 1'b0;
    cyc(); cyc();
    checks++;
    if ({bus4.out_valid, bus4.out_pc} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL c4_restart: got valid=%b pc=%h want 1/0", bus4.out_valid, bus4.out_pc);
    end
  endtask

  initial begin
    reset0              = 1'b1;
    reset4              = 1'b1;
    bus0.halt           = 1'b0;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc    = 32'd0;
    bus0.out_ready      = 1'b0;
    bus4.halt           = 1'b0;
    bus4.redirect_valid = 1'b0;
    bus4.redirect_pc    = 32'd0;
    bus4.out_ready      = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_cores4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
